// File: rtl/stochastic_pkg.sv
// Shared types and maximal-length LFSR tap table for the stochastic edge engine.
package stochastic_pkg;

  typedef enum logic {
    ROBERTS     = 1'b0,
    PREWITT_AVG = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit i set means state bit i feeds the XOR; each entry is a primitive polynomial.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/stochastic_edge_engine_lfsr.sv
// Fibonacci maximal-length LFSR with synchronous seed load and step enable.
module sc_lfsr
  import stochastic_pkg::*;
#(
  parameter int W    = 8,
  parameter int SEED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] state
);

  localparam logic [15:0]  TAP_ALL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS    = TAP_ALL[W-1:0];
  localparam logic [W-1:0] SEED_V  = SEED[W-1:0];

  // A zero seed would lock the register at zero forever.
  if (SEED_V == '0) begin : g_bad_seed
    $error("sc_lfsr: SEED must be nonzero within W bits");
  end
  if (W < 4 || W > 16) begin : g_bad_width
    $error("sc_lfsr: W must be in 4..16");
  end

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic         fb;

  always_comb begin
    fb     = ^(lfsr_q & TAPS);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED_V;
    end else if (step) begin
      lfsr_d = {lfsr_q[W-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED_V;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/stochastic_edge_engine.sv
// Stochastic-computing edge detector: correlated pixel bitstreams through an XOR/MUX
// gradient network, ones counted over one window.
module stochastic_edge_engine
  import stochastic_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int STREAM_LEN = 2**PIX_W-1,
  parameter int SEED_A     = 1,
  parameter int SEED_B     = 2**(PIX_W-1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              mode,
  input  logic [PIX_W-1:0]                  z1,
  input  logic [PIX_W-1:0]                  z2,
  input  logic [PIX_W-1:0]                  z3,
  input  logic [PIX_W-1:0]                  z4,
  input  logic [PIX_W-1:0]                  z6,
  input  logic [PIX_W-1:0]                  z7,
  input  logic [PIX_W-1:0]                  z8,
  input  logic [PIX_W-1:0]                  z9,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(STREAM_LEN+1)-1:0]   out_count,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and out_count is held
  // stable for as long as out_valid waits for out_ready.

  localparam int CW = $clog2(STREAM_LEN+1);

  if (STREAM_LEN < 1 || STREAM_LEN > 2**PIX_W-1) begin : g_bad_len
    $error("stochastic_edge_engine: STREAM_LEN must be in 1..2**PIX_W-1");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [PIX_W-1:0] pix_q [8];
  logic [PIX_W-1:0] pix_d [8];
  logic [CW-1:0]    run_q, run_d;
  logic [CW-1:0]    ones_q, ones_d;

  logic             accept;
  logic             running;
  logic [PIX_W-1:0] lfsr_a;
  logic [PIX_W-1:0] lfsr_b;
  logic [7:0]       bits;
  logic             s0, gx, gy, y;
  logic             pix_unused;

  assign accept  = in_valid && in_ready;
  assign running = (state_q == RUN);

  sc_lfsr #(.W(PIX_W), .SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (running),
    .state (lfsr_a)
  );

  sc_lfsr #(.W(PIX_W), .SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (running),
    .state (lfsr_b)
  );

  // Every pixel is compared with the same random value so the streams are correlated,
  // which turns XOR into absolute difference.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      bits[k] = (pix_q[k] >= lfsr_a);
    end
  end

  // Index map: 0=z1 1=z2 2=z3 3=z4 4=z6 5=z7 6=z8 7=z9.
  always_comb begin
    s0 = lfsr_b[0];
    gx = 1'b0;
    gy = 1'b0;
    if (mode_q == ROBERTS) begin
      gx = bits[0] ^ bits[7];
      gy = bits[2] ^ bits[5];
    end else begin
      gx = (s0 ? bits[5] : bits[0]) ^ (s0 ? bits[7] : bits[2]);
      gy = (s0 ? bits[2] : bits[0]) ^ (s0 ? bits[7] : bits[5]);
    end
    y = lfsr_b[PIX_W-1] ? gy : gx;
  end

  assign pix_unused = ^{bits[1], bits[3], bits[4], bits[6], lfsr_b[PIX_W-2:1]};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    run_d   = run_q;
    ones_d  = ones_q;
    for (int k = 0; k < 8; k++) begin
      pix_d[k] = pix_q[k];
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          mode_d   = mode_e'(mode);
          run_d    = '0;
          ones_d   = '0;
          pix_d[0] = z1;
          pix_d[1] = z2;
          pix_d[2] = z3;
          pix_d[3] = z4;
          pix_d[4] = z6;
          pix_d[5] = z7;
          pix_d[6] = z8;
          pix_d[7] = z9;
        end
      end
      RUN: begin
        ones_d = ones_q + CW'(y);
        run_d  = run_q + 1'b1;
        if (run_q == CW'(STREAM_LEN-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= ROBERTS;
      run_q   <= '0;
      ones_q  <= '0;
      for (int k = 0; k < 8; k++) begin
        pix_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
      ones_q  <= ones_d;
      for (int k = 0; k < 8; k++) begin
        pix_q[k] <= pix_d[k];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_count = ones_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stochastic_edge_engine.sv
// Self-checking bench for stochastic_edge_engine at default parameters, scoreboard driven.
module tb_stochastic_edge_engine;

  localparam int PIX_W = 8;
  localparam int L     = 255;
  localparam int CW    = 8;

  typedef logic [PIX_W-1:0] pix_arr_t [8];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mode = 1'b0;
  logic [PIX_W-1:0] z1 = '0, z2 = '0, z3 = '0, z4 = '0, z6 = '0, z7 = '0, z8 = '0, z9 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_count;
  logic          busy;
  logic [1:0]    dbg_state;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            acc_cyc = 0;
  int            res_cyc = 0;
  logic [CW-1:0] exp_q[$];

  stochastic_edge_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z6(z6), .z7(z7), .z8(z8), .z9(z9),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // x^8+x^6+x^5+x^4+1 Fibonacci step, written independently of the RTL table.
  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Reference model; index map 0=z1 1=z2 2=z3 3=z4 4=z6 5=z7 6=z8 7=z9.
  function automatic logic [CW-1:0] model(input pix_arr_t px, input logic m);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] bt;
    logic       gx, gy, s0, y;
    int         cnt;
    a = 8'd1;
    b = 8'h80;
    cnt = 0;
    for (int i = 0; i < L; i++) begin
      for (int k = 0; k < 8; k++) bt[k] = (px[k] >= a);
      s0 = b[0];
      if (!m) begin
        gx = bt[0] ^ bt[7];
        gy = bt[2] ^ bt[5];
      end else begin
        gx = (s0 ? bt[5] : bt[0]) ^ (s0 ? bt[7] : bt[2]);
        gy = (s0 ? bt[2] : bt[0]) ^ (s0 ? bt[7] : bt[5]);
      end
      y = b[7] ? gy : gx;
      cnt += int'(y);
      a = step8(a);
      b = step8(b);
    end
    return CW'(cnt);
  endfunction

  function automatic pix_arr_t fill(input logic [7:0] v);
    pix_arr_t p;
    for (int k = 0; k < 8; k++) p[k] = v;
    return p;
  endfunction

  function automatic pix_arr_t rand_pix();
    pix_arr_t p;
    for (int k = 0; k < 8; k++) p[k] = PIX_W'($urandom_range(0, 255));
    return p;
  endfunction

  task automatic drive_pix(input pix_arr_t px, input logic m);
    z1 = px[0]; z2 = px[1]; z3 = px[2]; z4 = px[3];
    z6 = px[4]; z7 = px[5]; z8 = px[6]; z9 = px[7];
    mode = m;
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_window(input pix_arr_t px, input logic m);
    int t;
    drive_pix(px, m);
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(px, m));
      acc_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_result(output logic ok, output logic [CW-1:0] got);
    int t;
    t = 0;
    while (!(out_valid && out_ready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ok = out_valid && out_ready;
    got = out_count;
    res_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_out_count got %0d exp 0", out_count); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_roberts_uniform();
    logic ok; logic [CW-1:0] got, e;
    out_ready = 1'b1;
    send_window(fill(8'd100), 1'b0);
    wait_result(ok, got);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL uniform_model got %0d exp %0d ok=%0b", got, e, ok); end
    checks++; if (got !== 8'd0) begin errors++; $display("FAIL uniform_const got %0d exp 0", got); end
    checks++; if (res_cyc - acc_cyc !== L + 1) begin errors++; $display("FAIL latency got %0d exp %0d", res_cyc - acc_cyc, L + 1); end
  endtask

  task automatic test_roberts_z1();
    logic ok; logic [CW-1:0] got, e;
    pix_arr_t p;
    p = fill(8'd0);
    p[0] = 8'd255;
    send_window(p, 1'b0);
    wait_result(ok, got);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL z1_model got %0d exp %0d ok=%0b", got, e, ok); end
    checks++; if (got !== 8'd127) begin errors++; $display("FAIL z1_const got %0d exp 127", got); end
  endtask

  task automatic test_stream_bits();
    logic ok; logic [CW-1:0] got, e;
    pix_arr_t p;
    logic [7:0] vals [4];
    vals[0] = 8'd1; vals[1] = 8'd37; vals[2] = 8'd200; vals[3] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      p = fill(8'd0);
      p[0] = vals[i];
      p[2] = vals[i];
      send_window(p, 1'b0);
      wait_result(ok, got);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e || got !== vals[i]) begin
        errors++;
        $display("FAIL stream_p%0d got %0d exp %0d model %0d", vals[i], got, vals[i], e);
      end
    end
  endtask

  task automatic test_prewitt();
    logic ok; logic [CW-1:0] got, e;
    pix_arr_t p;
    send_window(fill(8'd37), 1'b1);
    wait_result(ok, got);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== 8'd0 || got !== e) begin errors++; $display("FAIL prewitt_flat got %0d exp 0", got); end
    p = fill(8'd0);
    p[2] = 8'd255;
    p[7] = 8'd255;
    send_window(p, 1'b1);
    wait_result(ok, got);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL prewitt_edge got %0d exp %0d", got, e); end
  endtask

  task automatic test_random();
    logic ok; logic [CW-1:0] got, e;
    for (int i = 0; i < 3; i++) begin
      send_window(rand_pix(), 1'($urandom_range(0, 1)));
      wait_result(ok, got);
      e = exp_q.pop_front();
      checks++; if (!ok || got !== e) begin errors++; $display("FAIL random_%0d got %0d exp %0d", i, got, e); end
    end
  endtask

  task automatic test_hold();
    logic ok; logic [CW-1:0] got, e, cap;
    logic bad_ready, bad_stable;
    int t;
    pix_arr_t p;
    p = fill(8'd0);
    p[0] = 8'd255;
    out_ready = 1'b0;
    send_window(p, 1'b0);
    in_valid = 1'b1;
    bad_ready = 1'b0;
    bad_stable = 1'b0;
    t = 0;
    while (!out_valid && t < 1000) begin
      if (in_ready) bad_ready = 1'b1;
      drive_pix(rand_pix(), 1'($urandom_range(0, 1)));
      @(negedge clk);
      t++;
    end
    cap = out_count;
    for (int i = 0; i < 10; i++) begin
      drive_pix(rand_pix(), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (in_ready) bad_ready = 1'b1;
      if (out_valid !== 1'b1 || out_count !== cap) bad_stable = 1'b1;
    end
    checks++; if (bad_stable || !out_valid) begin errors++; $display("FAIL hold_stable got %0d/%0b exp %0d/1", out_count, out_valid, cap); end
    checks++; if (bad_ready) begin errors++; $display("FAIL hold_in_ready got 1 exp 0 while busy"); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_result(ok, got);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e || got !== 8'd127) begin errors++; $display("FAIL hold_result got %0d exp %0d", got, e); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_idle busy=%0b in_ready=%0b exp 0/1", busy, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    logic ok; logic [CW-1:0] got, e, clean;
    pix_arr_t p;
    p = rand_pix();
    send_window(p, 1'b1);
    wait_result(ok, got);
    e = exp_q.pop_front();
    clean = got;
    checks++; if (!ok || got !== e) begin errors++; $display("FAIL clean_run got %0d exp %0d", got, e); end
    send_window(p, 1'b1);
    repeat (49) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 8'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got rdy=%0b vld=%0b busy=%0b cnt=%0d st=%0d exp 1/0/0/0/0",
               in_ready, out_valid, busy, out_count, dbg_state);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_window(p, 1'b1);
    wait_result(ok, got);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e || got !== clean) begin errors++; $display("FAIL rerun got %0d exp %0d", got, clean); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) send_window(rand_pix(), 1'($urandom_range(0, 1)));
      end
      begin
        logic ok; logic [CW-1:0] got, e;
        int prev;
        prev = 0;
        for (int j = 0; j < 3; j++) begin
          wait_result(ok, got);
          e = exp_q.pop_front();
          checks++; if (!ok || got !== e) begin errors++; $display("FAIL b2b_%0d got %0d exp %0d", j, got, e); end
          if (j > 0) begin
            checks++;
            if (res_cyc - prev !== L + 2) begin errors++; $display("FAIL b2b_period got %0d exp %0d", res_cyc - prev, L + 2); end
          end
          prev = res_cyc;
        end
      end
    join
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_roberts_uniform();
    test_roberts_z1();
    test_stream_bits();
    test_prewitt();
    test_random();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
